sobel_frame_ctrl: RTL and testbench

Frame sequencer for the Sobel window generator. Accepts a raster pixel stream with start-of-frame marking and tracks row and column position. Drives the window generator's `pixel_valid`/pixel inputs and emits `win_valid` with centre coordinates only for fully populated interior 3x3 windows. Optionally injects a zero flush row at end of frame so the last interior row drains out.

---
 rtl/sobel_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding the Sobel window generator: raster position tracking,
// interior-window qualification, optional zero flush row (SOBEL_CTRL_FLUSH_EN).
module sobel_frame_ctrl #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_data,
  input  logic                     s_sof,
  output logic                     wg_pixel_valid,
  output logic [PIX_W-1:0]         wg_pixel,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     sync_err
);

  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  // one extra row code so the flush row IMG_H is representable
  localparam int RCW = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [RCW-1:0]   row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             win_valid_q, win_valid_d;
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;

  logic             xfer;
  logic             fwd;
  logic             fwd_zero;
  logic [RCW-1:0]   pos_r;
  logic [CW-1:0]    pos_c;

  assign s_ready = ~rst & (state_q != FLUSH);
  assign xfer    = s_valid & s_ready;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;
    fwd          = 1'b0;
    fwd_zero     = 1'b0;
    pos_r        = row_q;
    pos_c        = col_q;

    case (state_q)
      IDLE: begin
        if (xfer && s_sof) begin
          fwd     = 1'b1;
          pos_r   = '0;
          pos_c   = '0;
          row_d   = '0;
          col_d   = CW'(1);
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          fwd = 1'b1;
          // any sof here is out of place: restart the frame at this beat
          if (s_sof) begin
            sync_err_d = 1'b1;
            pos_r      = '0;
            pos_c      = '0;
            row_d      = '0;
            col_d      = CW'(1);
          end else if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RCW'(IMG_H - 1)) begin
`ifdef SOBEL_CTRL_FLUSH_EN
              row_d   = RCW'(IMG_H);
              state_d = FLUSH;
`else
              row_d        = '0;
              state_d      = IDLE;
              frame_done_d = 1'b1;
`endif
            end else begin
              row_d = row_q + RCW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
`ifdef SOBEL_CTRL_FLUSH_EN
      FLUSH: begin
        fwd      = 1'b1;
        fwd_zero = 1'b1;
        if (col_q == CW'(IMG_W - 1)) begin
          col_d        = '0;
          row_d        = '0;
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    win_valid_d = fwd && (pos_r >= RCW'(3)) && (pos_c >= CW'(2));
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (win_valid_d) begin
      win_row_d = RW'(pos_r - RCW'(2));
      win_col_d = pos_c - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign wg_pixel_valid = fwd;
  assign wg_pixel       = (fwd && !fwd_zero) ? s_data : '0;
  assign win_valid      = win_valid_q;
  assign win_row        = win_row_q;
  assign win_col        = win_col_q;
  assign frame_done     = frame_done_q;
  assign busy           = (state_q != IDLE);
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on an 8x6 image; follows SOBEL_CTRL_FLUSH_EN.
module tb_sobel_frame_ctrl;

  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
`ifdef SOBEL_CTRL_FLUSH_EN
  localparam int EXP_WIN = (H - 2) * (W - 2);
`else
  localparam int EXP_WIN = (H - 3) * (W - 2);
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [PW-1:0]            s_data = '0;
  logic                     s_sof = 1'b0;
  logic                     wg_pixel_valid;
  logic [PW-1:0]            wg_pixel;
  logic                     win_valid;
  logic [$clog2(H)-1:0]     win_row;
  logic [$clog2(W)-1:0]     win_col;
  logic                     frame_done;
  logic                     busy;
  logic                     sync_err;

  int n_chk = 0;
  int n_err = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int exp_q[$];
  bit in_frame = 0;

  sobel_frame_ctrl #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .wg_pixel_valid(wg_pixel_valid), .wg_pixel(wg_pixel),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // window scoreboard: every win_valid pops one expected centre
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (win_valid) begin
        win_cnt++;
        if (exp_q.size() == 0) chk("win_extra", int'(win_row) * 256 + int'(win_col), -1);
        else chk("win_pos", int'(win_row) * 256 + int'(win_col), exp_q.pop_front());
      end
    end
  end

  // entered and left at negedge+1
  task automatic beat(input int r, input int c, input logic [PW-1:0] d, input logic sof, input int g);
    bit fwd_exp, win_exp;
    repeat (g) begin
      @(negedge clk);
      #1;
    end
    if (sof) in_frame = 1;
    fwd_exp = in_frame;
    win_exp = fwd_exp && r >= 3 && c >= 2;
    if (win_exp) exp_q.push_back((r - 2) * 256 + (c - 1));
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    #1;
    chk("s_ready", s_ready, 1);
    chk("wg_valid", wg_pixel_valid, fwd_exp);
    chk("wg_pixel", wg_pixel, fwd_exp ? int'(d) : 0);
    @(negedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    chk("win_latency", win_valid, win_exp);
    if (win_exp) chk("win_lat_pos", int'(win_row) * 256 + int'(win_col), (r - 2) * 256 + (c - 1));
  endtask

  task automatic end_frame();
`ifdef SOBEL_CTRL_FLUSH_EN
    int  low;
    bit  seen;
    low  = 0;
    seen = 0;
    for (int c = 2; c < W; c++) exp_q.push_back((H - 2) * 256 + (c - 1));
    for (int i = 0; i < 30 && !seen; i++) begin
      if (!s_ready) low++;
      if (wg_pixel_valid && wg_pixel !== '0) chk("flush_zero", wg_pixel, 0);
      if (frame_done) begin
        seen = 1;
        chk("done_win", win_valid, 1);
        chk("done_pos", int'(win_row) * 256 + int'(win_col), (H - 2) * 256 + (W - 2));
        chk("done_busy", busy, 0);
      end else begin
        @(negedge clk);
        #1;
      end
    end
    chk("frame_done_seen", seen, 1);
    chk("ready_low", low, W);
`else
    chk("frame_done", frame_done, 1);
    chk("done_busy", busy, 0);
    chk("ready_after", s_ready, 1);
`endif
    @(negedge clk);
    #1;
    chk("done_pulse", frame_done, 0);
  endtask

  task automatic send_frame(input int gmax, input int stop_r, input int stop_c, input int seed);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        beat(r, c, PW'(seed + r * 16 + c), (r == 0 && c == 0), $urandom_range(0, gmax));
      end
    in_frame = 0;
    end_frame();
  endtask

  task automatic rst_check();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_wgv", wg_pixel_valid, 0);
    chk("rst_wgp", wg_pixel, 0);
    chk("rst_win", win_valid, 0);
    chk("rst_pos", int'(win_row) * 256 + int'(win_col), 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", sync_err, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    in_frame = 0;
    repeat (W + 2) begin
      @(negedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_wgv", wg_pixel_valid, 0);
    end
  endtask

  int w0, d0;

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset_ready", s_ready, 0);
    chk("reset_wgv", wg_pixel_valid, 0);
    chk("reset_win", win_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", sync_err, 0);
    chk("reset_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // 1: gap-free frame
    w0 = win_cnt;
    send_frame(0, -1, -1, 0);
    chk("s1_wins", win_cnt - w0, EXP_WIN);
    chk("s1_q", exp_q.size(), 0);

    // 2: random gaps
    w0 = win_cnt;
    send_frame(2, -1, -1, 0);
    chk("s2_wins", win_cnt - w0, EXP_WIN);
    chk("s2_q", exp_q.size(), 0);

    // 3: junk beats before sof
    w0 = win_cnt;
    for (int i = 0; i < 5; i++) beat(0, 0, PW'(8'hA0 + i), 1'b0, 0);
    send_frame(0, -1, -1, 7);
    chk("s3_wins", win_cnt - w0, EXP_WIN);
    chk("s3_q", exp_q.size(), 0);

    // 4: unexpected sof at (2,5)
    chk("s4_err_pre", sync_err, 0);
    send_frame(0, 2, 5, 3);
    d0 = done_cnt;
    w0 = win_cnt;
    send_frame(1, -1, -1, 9);
    chk("s4_err", sync_err, 1);
    chk("s4_wins", win_cnt - w0, EXP_WIN);
    chk("s4_done", done_cnt - d0, 1);
    chk("s4_q", exp_q.size(), 0);

    // 5: reset mid-frame (inside the flush row when present)
`ifdef SOBEL_CTRL_FLUSH_EN
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) beat(r, c, PW'(r + c), (r == 0 && c == 0), 0);
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    chk("s5_in_flush", s_ready, 0);
`else
    send_frame(0, 4, 3, 5);
`endif
    rst_check();
    w0 = win_cnt;
    send_frame(0, -1, -1, 11);
    chk("s5_wins", win_cnt - w0, EXP_WIN);
    chk("s5_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
